// File: rtl/sim_step_scheduler_if.sv
// Scheduler control/status bundle: run/clear control, datapath handshake,
// and the committed step outputs. The scheduler uses the master modport.
interface sim_step_scheduler_if #(
  parameter int unsigned WIDTH_TIME = 32,
  parameter int unsigned DATA_W     = 64
);
  logic                  run;
  logic                  clear;
  logic                  dp_done;
  logic [DATA_W-1:0]     Tm_temp;
  logic                  dp_start;
  logic [WIDTH_TIME-1:0] sim_time;
  logic [DATA_W-1:0]     Tm;
  logic                  step_tick;
  logic                  overrun;
  logic                  sim_end;
  logic                  busy;

  modport master (
    input  run, clear, dp_done, Tm_temp,
    output dp_start, sim_time, Tm, step_tick, overrun, sim_end, busy
  );

  modport slave (
    output run, clear, dp_done, Tm_temp,
    input  dp_start, sim_time, Tm, step_tick, overrun, sim_end, busy
  );
endinterface

// File: rtl/sim_step_scheduler.sv
// Fixed-period simulation step sequencer: launches the datapath each step,
// commits its torque result on the period tick and flags late completions.
module sim_step_scheduler #(
  parameter int unsigned       WIDTH_TIME  = 32,
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       STEP_CYCLES = 500,
  parameter int unsigned       INIT_STEPS  = 10000,
  parameter logic [DATA_W-1:0] INIT_VALUE  = 64'h3FE000346DC5D639
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sim_step_scheduler_if.master bus
);

  localparam int unsigned CYC_W = $clog2(STEP_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(STEP_CYCLES - 1);
  // Wide enough for sim_time+1 without wrap and for INIT_STEPS unchanged.
  localparam int unsigned CMP_W = (WIDTH_TIME + 1 > 32) ? WIDTH_TIME + 1 : 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    WAIT_TICK = 2'd3
  } state_t;

  state_t                state_q;
  logic [CYC_W-1:0]      cyc_q;
  logic [WIDTH_TIME-1:0] sim_time_q;
  logic [DATA_W-1:0]     tm_q;
  logic [DATA_W-1:0]     cap_q;
  logic                  dp_start_q;
  logic                  step_tick_q;
  logic                  overrun_q;
  logic                  sim_end_q;

  logic                  tick;
  logic                  commit;
  logic                  saturated;
  logic [CMP_W-1:0]      time_inc;
  logic                  init_win;
  logic [DATA_W-1:0]     commit_val;
  logic [DATA_W-1:0]     tm_d;
  logic [WIDTH_TIME-1:0] sim_time_d;

  always_comb begin
    tick       = (cyc_q == CYC_LAST);
    commit     = tick && (((state_q == WAIT_DONE) && bus.dp_done) ||
                          (state_q == WAIT_TICK));
    saturated  = &sim_time_q;
    time_inc   = CMP_W'(sim_time_q) + CMP_W'(1);
    init_win   = (time_inc <= CMP_W'(INIT_STEPS));
    // A same-cycle completion bypasses the capture register.
    commit_val = (state_q == WAIT_DONE) ? bus.Tm_temp : cap_q;
    tm_d       = init_win ? INIT_VALUE : commit_val;
    sim_time_d = saturated ? sim_time_q : time_inc[WIDTH_TIME-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      sim_time_q  <= '0;
      tm_q        <= INIT_VALUE;
      cap_q       <= '0;
      dp_start_q  <= 1'b0;
      step_tick_q <= 1'b0;
      overrun_q   <= 1'b0;
      sim_end_q   <= 1'b0;
    end else begin
      dp_start_q  <= 1'b0;
      step_tick_q <= 1'b0;
      if (bus.clear) begin
        state_q    <= IDLE;
        cyc_q      <= '0;
        sim_time_q <= '0;
        tm_q       <= INIT_VALUE;
        overrun_q  <= 1'b0;
        sim_end_q  <= 1'b0;
      end else if (commit) begin
        sim_time_q  <= sim_time_d;
        sim_end_q   <= saturated;
        tm_q        <= tm_d;
        step_tick_q <= 1'b1;
        cyc_q       <= '0;
        if (state_q == WAIT_DONE) begin
          cap_q <= bus.Tm_temp;
        end
        if (bus.run && !saturated) begin
          state_q    <= LAUNCH;
          dp_start_q <= 1'b1;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.run && !sim_end_q) begin
              state_q    <= LAUNCH;
              cyc_q      <= '0;
              dp_start_q <= 1'b1;
            end
          end
          LAUNCH: begin
            cyc_q   <= cyc_q + CYC_W'(1);
            state_q <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (bus.dp_done) begin
              cap_q   <= bus.Tm_temp;
              cyc_q   <= cyc_q + CYC_W'(1);
              state_q <= WAIT_TICK;
            end else if (tick) begin
              // Late step: hold at the last count until the datapath finishes.
              overrun_q <= 1'b1;
            end else begin
              cyc_q <= cyc_q + CYC_W'(1);
            end
          end
          WAIT_TICK: begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dp_start  = dp_start_q;
  assign bus.sim_time  = sim_time_q;
  assign bus.Tm        = tm_q;
  assign bus.step_tick = step_tick_q;
  assign bus.overrun   = overrun_q;
  assign bus.sim_end   = sim_end_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Scoreboard bench for sim_step_scheduler: stimulus pushes the expected commit,
// a monitor pops and compares on every step_tick.
module tb_sim_step_scheduler;
  localparam int unsigned WT = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned SC = 8;
  localparam int unsigned IS = 3;
  localparam logic [63:0] INITV = 64'h3FE000346DC5D639;
  localparam logic [63:0] BASE  = 64'h4000000000000000;

  typedef struct {
    int          t;
    logic [63:0] tm;
    logic        ovr;
    int          spacing;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   exp_time;
  logic exp_ovr;
  int   cyc_n = 0;
  int   last_tick = 0;

  sim_step_scheduler_if #(.WIDTH_TIME(WT), .DATA_W(DW)) bus_if ();

  sim_step_scheduler #(
    .WIDTH_TIME (WT),
    .DATA_W     (DW),
    .STEP_CYCLES(SC),
    .INIT_STEPS (IS),
    .INIT_VALUE (INITV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tv(int k);
    return BASE + (64'(k) << 16);
  endfunction

  // Monitor: one expected entry per step commit.
  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (rst_n === 1'b1 && bus_if.step_tick === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: got step_tick=1 sim_time=%0d expected no commit",
                 bus_if.sim_time);
      end else begin
        e = q.pop_front();
        check("commit_sim_time", 64'(bus_if.sim_time), 64'(e.t));
        check("commit_Tm", bus_if.Tm, e.tm);
        check("commit_overrun", 64'(bus_if.overrun), 64'(e.ovr));
        if (e.spacing != 0) check("step_spacing", 64'(cyc_n - last_tick), 64'(e.spacing));
      end
      last_tick = cyc_n;
    end
  end

  task automatic push_exp(int d, logic [63:0] val, int spacing);
    exp_t e;
    if (d > int'(SC) - 1) exp_ovr = 1'b1;
    e.tm = ((exp_time + 1) <= int'(IS)) ? INITV : val;
    if (exp_time != 15) exp_time++;
    e.t = exp_time;
    e.ovr = exp_ovr;
    e.spacing = spacing;
    q.push_back(e);
  endtask

  task automatic wait_launch(output bit ok);
    int n = 0;
    while (bus_if.dp_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (bus_if.dp_start === 1'b1);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL dp_start_timeout: got dp_start=%b after %0d cycles expected 1", bus_if.dp_start, n);
    end
  endtask

  // Datapath stand-in: dp_done d cycles after the dp_start cycle.
  task automatic do_step(int d, logic [63:0] val, int spacing, int drop_at);
    bit ok;
    wait_launch(ok);
    if (!ok) return;
    for (int j = 1; j <= d; j++) begin
      @(negedge clk);
      if (j == drop_at) bus_if.run = 1'b0;
    end
    push_exp(d, val, spacing);
    bus_if.dp_done = 1'b1;
    bus_if.Tm_temp = val;
    @(negedge clk);
    bus_if.dp_done = 1'b0;
  endtask

  task automatic check_all_reset(string tag);
    check({tag, "_sim_time"}, 64'(bus_if.sim_time), 64'd0);
    check({tag, "_Tm"}, bus_if.Tm, INITV);
    check({tag, "_dp_start"}, 64'(bus_if.dp_start), 64'd0);
    check({tag, "_step_tick"}, 64'(bus_if.step_tick), 64'd0);
    check({tag, "_overrun"}, 64'(bus_if.overrun), 64'd0);
    check({tag, "_sim_end"}, 64'(bus_if.sim_end), 64'd0);
    check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bit quiet;
    bus_if.run = 1'b0;
    bus_if.clear = 1'b0;
    bus_if.dp_done = 1'b0;
    bus_if.Tm_temp = '0;
    rst_n = 1'b0;
    exp_time = 0;
    exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic stepping across the start-up window
    bus_if.run = 1'b1;
    for (int k = 1; k <= 4; k++) do_step(3, tv(k - 4), (k == 1) ? 0 : int'(SC), 0);

    // run dropped at cyc=2 of step 5
    do_step(3, tv(5), SC, 2);
    repeat (4) @(negedge clk);
    check("run_drop_sim_time", 64'(bus_if.sim_time), 64'd5);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus_if.busy !== 1'b0 || bus_if.dp_start !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("run_drop_idle", 64'(quiet), 64'd1);
    bus_if.run = 1'b1;
    @(negedge clk);
    check("rerun_dp_start", 64'(bus_if.dp_start), 64'd1);

    // Coincident dp_done and tick, then late completion, then on-time
    do_step(7, tv(6), 0, 0);
    do_step(7, tv(7), SC, 0);
    do_step(10, tv(8), 11, 0);
    do_step(3, tv(9), SC, 0);

    // clear in WAIT_DONE with overrun set
    wait_launch(ok);
    repeat (2) @(negedge clk);
    check("overrun_sticky", 64'(bus_if.overrun), 64'd1);
    bus_if.clear = 1'b1;
    bus_if.run = 1'b0;
    @(negedge clk);
    bus_if.clear = 1'b0;
    exp_time = 0;
    exp_ovr = 1'b0;
    check_all_reset("clear");
    bus_if.dp_done = 1'b1;
    bus_if.Tm_temp = tv(50);
    @(negedge clk);
    bus_if.dp_done = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_done_sim_time", 64'(bus_if.sim_time), 64'd0);
    check("stray_done_Tm", bus_if.Tm, INITV);
    check("stray_done_busy", 64'(bus_if.busy), 64'd0);

    // Saturation at sim_time all-ones
    bus_if.run = 1'b1;
    for (int i = 1; i <= 16; i++) do_step(3, tv(100 + i), (i == 1) ? 0 : int'(SC), 0);
    repeat (4) @(negedge clk);
    check("sat_sim_end", 64'(bus_if.sim_end), 64'd1);
    check("sat_sim_time", 64'(bus_if.sim_time), 64'd15);
    check("sat_busy", 64'(bus_if.busy), 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.dp_start !== 1'b0 || bus_if.busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("sat_no_launch", 64'(quiet), 64'd1);
    bus_if.clear = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
    exp_time = 0;
    exp_ovr = 1'b0;
    check("sat_clear_sim_end", 64'(bus_if.sim_end), 64'd0);
    check("sat_clear_sim_time", 64'(bus_if.sim_time), 64'd0);
    check("sat_clear_busy", 64'(bus_if.busy), 64'd0);

    // Restart after clear, then async reset mid-step
    do_step(10, tv(200), 0, 0);
    do_step(3, tv(201), SC, 0);
    wait_launch(ok);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 64'(bus_if.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_reset("async_reset");
    bus_if.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
